// File: rtl/scr1_dmem_arb2.sv
// Two-master arbiter in front of the dmem AHB bridge, with an in-order owner tag FIFO for response steering.
// Latency: requests and responses pass through combinationally (zero cycles); only the tag/count state is registered.
// Backpressure: s_req_ack stalls the granted master in place; requests are held off while OUTSTD_DEPTH are outstanding.
module scr1_dmem_arb2 #(
  parameter int OUTSTD_DEPTH = 2,
  parameter bit RR_EN        = 1'b1,
  localparam int CW          = $clog2(OUTSTD_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  // master 0 (LSU)
  input  logic          m0_req,
  output logic          m0_req_ack,
  input  logic          m0_cmd,
  input  logic [1:0]    m0_width,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic [31:0]   m0_rdata,
  output logic [1:0]    m0_resp,
  // master 1 (debug / DMA)
  input  logic          m1_req,
  output logic          m1_req_ack,
  input  logic          m1_cmd,
  input  logic [1:0]    m1_width,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic [31:0]   m1_rdata,
  output logic [1:0]    m1_resp,
  // bridge side
  output logic          s_req,
  input  logic          s_req_ack,
  output logic          s_cmd,
  output logic [1:0]    s_width,
  output logic [31:0]   s_addr,
  output logic [31:0]   s_wdata,
  input  logic [31:0]   s_rdata,
  input  logic [1:0]    s_resp,
  // status
  output logic [CW-1:0] outst_cnt,
  output logic          err_unexp
);

  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_ER     = 2'b10;

  // Registered state
  logic [CW-1:0]           cnt_q,  cnt_d;
  logic [OUTSTD_DEPTH-1:0] tag_q,  tag_d;   // tag_q[0] is the oldest outstanding owner
  logic                    last_q, last_d;  // owner of the most recent accept
  logic                    err_q,  err_d;

  // Combinational intermediates
  logic          full;
  logic          empty;
  logic          gnt1;
  logic          accept;
  logic          resp_vld;
  logic          pop;
  logic          head;
  logic [1:0]    resp_eff;
  logic [CW-1:0] wr_idx;

  assign full  = (cnt_q == CW'(OUTSTD_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = tag_q[0];

  // Grant and request forwarding; the grant only moves when last_q changes, i.e. on an accept
  always_comb begin
    gnt1   = m1_req & ~(m0_req & (~RR_EN | last_q));
    s_req  = (m0_req | m1_req) & ~full;
    accept = s_req & s_req_ack;
    m0_req_ack = accept & ~gnt1;
    m1_req_ack = accept &  gnt1;
    s_cmd   = gnt1 ? m1_cmd   : m0_cmd;
    s_width = gnt1 ? m1_width : m0_width;
    s_addr  = gnt1 ? m1_addr  : m0_addr;
    s_wdata = gnt1 ? m1_wdata : m0_wdata;
  end

  // Response steering to the owner at the FIFO head; the reserved 11 code is folded into an error
  always_comb begin
    resp_vld = (s_resp != RESP_NOTRDY);
    resp_eff = (s_resp == 2'b11) ? RESP_ER : s_resp;
    pop      = resp_vld & ~empty;
    m0_resp  = RESP_NOTRDY;
    m1_resp  = RESP_NOTRDY;
    m0_rdata = '0;
    m1_rdata = '0;
    if (pop) begin
      if (head) begin
        m1_resp  = resp_eff;
        m1_rdata = s_rdata;
      end else begin
        m0_resp  = resp_eff;
        m0_rdata = s_rdata;
      end
    end
  end

  // Next-state for the counter, the shift-style tag FIFO, the RR pointer and the sticky error
  always_comb begin
    cnt_d  = cnt_q;
    tag_d  = tag_q;
    last_d = last_q;
    err_d  = err_q | (resp_vld & empty);
    wr_idx = pop ? (cnt_q - CW'(1)) : cnt_q;

    if (accept && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!accept && pop) begin
      cnt_d = cnt_q - CW'(1);
    end

    if (pop) begin
      tag_d = tag_q >> 1;
    end
    if (accept) begin
      last_d = gnt1;
      for (int i = 0; i < OUTSTD_DEPTH; i++) begin
        if (wr_idx == CW'(i)) begin
          tag_d[i] = gnt1;
        end
      end
    end
  end

  // State registers; last_q resets to 1 so master 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tag_q  <= '0;
      last_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  assign outst_cnt = cnt_q;
  assign err_unexp = err_q;

endmodule

// File: tb/tb_scr1_dmem_arb2.sv
// Self-checking bench for scr1_dmem_arb2: round-robin instance plus a fixed-priority instance on shared stimulus.
// Accepted owners are pushed to a scoreboard queue; each response pops it to derive the expected routing.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_scr1_dmem_arb2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_cmd, m1_req, m1_cmd;
  logic [1:0]  m0_width, m1_width;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        s_req_ack;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;

  logic        m0_req_ack, m1_req_ack, s_req, s_cmd, err_unexp;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [1:0]  m0_resp, m1_resp, s_width, outst_cnt;

  logic        fp_m0_req_ack, fp_m1_req_ack, fp_s_req, fp_s_cmd, fp_err_unexp;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [1:0]  fp_m0_resp, fp_m1_resp, fp_s_width, fp_outst_cnt;

  int total = 0;
  int bad   = 0;
  bit sb[$];      // expected owner of each outstanding request, oldest first
  bit exp_last;   // model of the owner granted at the last accept

  always #5 clk = ~clk;

  scr1_dmem_arb2 #(.OUTSTD_DEPTH(2), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_req_ack(m0_req_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
    .m1_req(m1_req), .m1_req_ack(m1_req_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
    .s_req(s_req), .s_req_ack(s_req_ack), .s_cmd(s_cmd), .s_width(s_width),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_resp(s_resp),
    .outst_cnt(outst_cnt), .err_unexp(err_unexp)
  );

  scr1_dmem_arb2 #(.OUTSTD_DEPTH(2), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_req_ack(fp_m0_req_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(fp_m0_rdata), .m0_resp(fp_m0_resp),
    .m1_req(m1_req), .m1_req_ack(fp_m1_req_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(fp_m1_rdata), .m1_resp(fp_m1_resp),
    .s_req(fp_s_req), .s_req_ack(s_req_ack), .s_cmd(fp_s_cmd), .s_width(fp_s_width),
    .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_rdata(s_rdata), .s_resp(s_resp),
    .outst_cnt(fp_outst_cnt), .err_unexp(fp_err_unexp)
  );

  // Reference arbitration: returns 1 when master 1 should be granted
  function automatic bit model_gnt(input bit r0, input bit r1, input bit rr, input bit last);
    if (r0 && r1) return rr ? ~last : 1'b0;
    return r1 && !r0;
  endfunction

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_cmd = 0; m1_cmd = 1;
    m0_width = 2'b10; m1_width = 2'b10;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'hA0A0_0000; m1_wdata = 32'hB1B1_0000;
    s_req_ack = 0; s_rdata = 32'h0; s_resp = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    total++; if (outst_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", outst_cnt); end
    total++; if (err_unexp !== 1'b0) begin bad++; $display("FAIL reset_err got %0b want 0", err_unexp); end
    total++; if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== 68'h0) begin
      bad++; $display("FAIL reset_resp got %h want 0", {m0_resp, m0_rdata, m1_resp, m1_rdata}); end
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL reset_sreq_idle got %0b want 0", s_req); end
    m0_req = 1;
    #1;
    total++; if (s_req !== 1'b1) begin bad++; $display("FAIL reset_sreq_follow got %0b want 1", s_req); end
    m0_req = 0;
    @(negedge clk);
    rst_n = 1;
    sb.delete();
    exp_last = 1;
    tick();
  endtask

  task automatic test_single_read();
    bit o; logic [67:0] ev;
    m0_req = 1; m0_cmd = 0; m0_addr = 32'h100; s_req_ack = 1;
    @(negedge clk);
    total++; if ({s_req, m0_req_ack, m1_req_ack} !== 3'b110) begin
      bad++; $display("FAIL single_ack got %b want 110", {s_req, m0_req_ack, m1_req_ack}); end
    total++; if (s_addr !== 32'h100 || s_cmd !== 1'b0) begin
      bad++; $display("FAIL single_fwd got %h/%b want 100/0", s_addr, s_cmd); end
    sb.push_back(1'b0); exp_last = 0;
    tick();
    total++; if (outst_cnt !== 2'd1) begin bad++; $display("FAIL single_cnt1 got %0d want 1", outst_cnt); end
    m0_req = 0; s_req_ack = 0; s_resp = 2'b01; s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL single_route got response want none"); end
    else begin
      o = sb.pop_front();
      ev = o ? {2'b00, 32'h0, 2'b01, 32'hDEADBEEF} : {2'b01, 32'hDEADBEEF, 2'b00, 32'h0};
      if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== ev) begin
        bad++; $display("FAIL single_route got %h want %h", {m0_resp, m0_rdata, m1_resp, m1_rdata}, ev); end
    end
    tick();
    s_resp = 2'b00;
    total++; if (outst_cnt !== 2'd0) begin bad++; $display("FAIL single_cnt0 got %0d want 0", outst_cnt); end
  endtask

  task automatic test_round_robin();
    bit g, o; logic [67:0] ev;
    m0_req = 1; m1_req = 1; m0_addr = 32'h200; m1_addr = 32'h300; s_req_ack = 1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin s_resp = 2'b01; s_rdata = 32'h1000 + k; end
      @(negedge clk);
      if (k > 0) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL rr_route%0d got response want none", k); end
        else begin
          o = sb.pop_front();
          ev = o ? {2'b00, 32'h0, 2'b01, s_rdata} : {2'b01, s_rdata, 2'b00, 32'h0};
          if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== ev) begin
            bad++; $display("FAIL rr_route%0d got %h want %h", k, {m0_resp, m0_rdata, m1_resp, m1_rdata}, ev); end
        end
      end
      g = model_gnt(1, 1, 1, exp_last);
      total++; if ({m0_req_ack, m1_req_ack} !== {~g, g} || s_addr !== (g ? 32'h300 : 32'h200)) begin
        bad++; $display("FAIL rr_grant%0d got ack=%b addr=%h want ack=%b", k, {m0_req_ack, m1_req_ack}, s_addr, {~g, g}); end
      total++; if ({fp_m0_req_ack, fp_m1_req_ack} !== 2'b10) begin
        bad++; $display("FAIL fp_grant%0d got %b want 10", k, {fp_m0_req_ack, fp_m1_req_ack}); end
      sb.push_back(g); exp_last = g;
      tick();
    end
    m0_req = 0; m1_req = 0; s_req_ack = 0; s_resp = 2'b01; s_rdata = 32'h1007;
    @(negedge clk);
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL rr_drain got response want none"); end
    else begin
      o = sb.pop_front();
      ev = o ? {2'b00, 32'h0, 2'b01, 32'h1007} : {2'b01, 32'h1007, 2'b00, 32'h0};
      if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== ev) begin
        bad++; $display("FAIL rr_drain got %h want %h", {m0_resp, m0_rdata, m1_resp, m1_rdata}, ev); end
    end
    tick();
    s_resp = 2'b00;
    total++; if (outst_cnt !== 2'd0) begin bad++; $display("FAIL rr_cnt got %0d want 0", outst_cnt); end
  endtask

  task automatic test_pipelined_order();
    bit o; logic [67:0] ev; logic [31:0] dat;
    m1_req = 1; m1_addr = 32'h400; s_req_ack = 1;
    @(negedge clk);
    total++; if ({m0_req_ack, m1_req_ack} !== 2'b01) begin
      bad++; $display("FAIL pipe_ack_m1 got %b want 01", {m0_req_ack, m1_req_ack}); end
    sb.push_back(1'b1); exp_last = 1;
    tick();
    m1_req = 0; m0_req = 1; m0_addr = 32'h500;
    @(negedge clk);
    total++; if ({m0_req_ack, m1_req_ack} !== 2'b10) begin
      bad++; $display("FAIL pipe_ack_m0 got %b want 10", {m0_req_ack, m1_req_ack}); end
    sb.push_back(1'b0); exp_last = 0;
    tick();
    total++; if (outst_cnt !== 2'd2) begin bad++; $display("FAIL pipe_cnt2 got %0d want 2", outst_cnt); end
    m0_req = 0; s_req_ack = 0;
    for (int k = 0; k < 2; k++) begin
      dat = (k == 0) ? 32'h11 : 32'h22;
      s_resp = 2'b01; s_rdata = dat;
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL pipe_route%0d got response want none", k); end
      else begin
        o = sb.pop_front();
        ev = o ? {2'b00, 32'h0, 2'b01, dat} : {2'b01, dat, 2'b00, 32'h0};
        if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== ev) begin
          bad++; $display("FAIL pipe_route%0d got %h want %h", k, {m0_resp, m0_rdata, m1_resp, m1_rdata}, ev); end
      end
      tick();
      total++; if (outst_cnt !== 2'(1 - k)) begin bad++; $display("FAIL pipe_cnt_after%0d got %0d want %0d", k, outst_cnt, 1 - k); end
    end
    s_resp = 2'b00;
  endtask

  task automatic test_full_stall();
    bit g, g0, o; logic [67:0] ev;
    m0_req = 1; m1_req = 1; m0_addr = 32'h600; m1_addr = 32'h700; s_req_ack = 0;
    g0 = model_gnt(1, 1, 1, exp_last);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if ({s_req, m0_req_ack, m1_req_ack} !== 3'b100 || s_addr !== (g0 ? 32'h700 : 32'h600)) begin
        bad++; $display("FAIL stall%0d got req/ack=%b addr=%h want 100 addr for m%0d", k, {s_req, m0_req_ack, m1_req_ack}, s_addr, g0); end
      tick();
    end
    s_req_ack = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      g = model_gnt(1, 1, 1, exp_last);
      total++; if ({m0_req_ack, m1_req_ack} !== {~g, g}) begin
        bad++; $display("FAIL fill%0d got %b want %b", k, {m0_req_ack, m1_req_ack}, {~g, g}); end
      sb.push_back(g); exp_last = g;
      tick();
    end
    total++; if (outst_cnt !== 2'd2) begin bad++; $display("FAIL full_cnt got %0d want 2", outst_cnt); end
    @(negedge clk);
    total++; if ({s_req, m0_req_ack, m1_req_ack} !== 3'b000) begin
      bad++; $display("FAIL full_block got %b want 000", {s_req, m0_req_ack, m1_req_ack}); end
    tick();
    s_resp = 2'b01; s_rdata = 32'h33;
    @(negedge clk);
    total++; if ({s_req, m0_req_ack, m1_req_ack} !== 3'b000) begin
      bad++; $display("FAIL full_pop_nobypass got %b want 000", {s_req, m0_req_ack, m1_req_ack}); end
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL full_route got response want none"); end
    else begin
      o = sb.pop_front();
      ev = o ? {2'b00, 32'h0, 2'b01, 32'h33} : {2'b01, 32'h33, 2'b00, 32'h0};
      if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== ev) begin
        bad++; $display("FAIL full_route got %h want %h", {m0_resp, m0_rdata, m1_resp, m1_rdata}, ev); end
    end
    tick();
    s_resp = 2'b00;
    total++; if (outst_cnt !== 2'd1) begin bad++; $display("FAIL full_cnt_pop got %0d want 1", outst_cnt); end
    @(negedge clk);
    g = model_gnt(1, 1, 1, exp_last);
    total++; if ({s_req, m0_req_ack, m1_req_ack} !== {1'b1, ~g, g}) begin
      bad++; $display("FAIL full_next_accept got %b want %b", {s_req, m0_req_ack, m1_req_ack}, {1'b1, ~g, g}); end
    sb.push_back(g); exp_last = g;
    tick();
    m0_req = 0; m1_req = 0; s_req_ack = 0;
    for (int k = 0; k < 2; k++) begin
      s_resp = 2'b01; s_rdata = 32'h4400 + k;
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL full_drain%0d got response want none", k); end
      else begin
        o = sb.pop_front();
        ev = o ? {2'b00, 32'h0, 2'b01, s_rdata} : {2'b01, s_rdata, 2'b00, 32'h0};
        if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== ev) begin
          bad++; $display("FAIL full_drain%0d got %h want %h", k, {m0_resp, m0_rdata, m1_resp, m1_rdata}, ev); end
      end
      tick();
    end
    s_resp = 2'b00;
    total++; if (outst_cnt !== 2'd0) begin bad++; $display("FAIL full_drained got %0d want 0", outst_cnt); end
  endtask

  task automatic test_error_unexpected();
    m1_req = 1; m1_addr = 32'h800; s_req_ack = 1;
    @(negedge clk);
    total++; if (m1_req_ack !== 1'b1) begin bad++; $display("FAIL err_ack_m1 got %b want 1", m1_req_ack); end
    sb.push_back(1'b1); exp_last = 1;
    tick();
    m1_req = 0; s_req_ack = 0; s_resp = 2'b10; s_rdata = 32'h55;
    @(negedge clk);
    void'(sb.pop_front());
    total++; if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== {2'b00, 32'h0, 2'b10, 32'h55}) begin
      bad++; $display("FAIL err_route got %h want m1 resp 10", {m0_resp, m0_rdata, m1_resp, m1_rdata}); end
    tick();
    total++; if (outst_cnt !== 2'd0) begin bad++; $display("FAIL err_cnt got %0d want 0", outst_cnt); end
    m0_req = 1; m0_addr = 32'h900; s_req_ack = 1; s_resp = 2'b00;
    @(negedge clk);
    sb.push_back(1'b0); exp_last = 0;
    tick();
    m0_req = 0; s_req_ack = 0; s_resp = 2'b11; s_rdata = 32'h66;
    @(negedge clk);
    void'(sb.pop_front());
    total++; if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== {2'b10, 32'h66, 2'b00, 32'h0}) begin
      bad++; $display("FAIL err_code11 got %h want m0 resp 10", {m0_resp, m0_rdata, m1_resp, m1_rdata}); end
    tick();
    s_resp = 2'b01; s_rdata = 32'h77;
    @(negedge clk);
    total++; if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== 68'h0) begin
      bad++; $display("FAIL unexp_drop got %h want 0", {m0_resp, m0_rdata, m1_resp, m1_rdata}); end
    tick();
    s_resp = 2'b00;
    total++; if (err_unexp !== 1'b1) begin bad++; $display("FAIL unexp_set got %b want 1", err_unexp); end
    tick(); tick();
    total++; if (err_unexp !== 1'b1 || outst_cnt !== 2'd0) begin
      bad++; $display("FAIL unexp_sticky got err=%b cnt=%0d want err=1 cnt=0", err_unexp, outst_cnt); end
  endtask

  task automatic test_reset_mid();
    m0_req = 1; m0_addr = 32'hA00; s_req_ack = 1;
    @(negedge clk);
    tick();
    m0_req = 0; m1_req = 1; m1_addr = 32'hB00;
    @(negedge clk);
    tick();
    total++; if (outst_cnt !== 2'd2) begin bad++; $display("FAIL rmid_pre_cnt got %0d want 2", outst_cnt); end
    m1_req = 0; s_req_ack = 0; m0_req = 1;
    rst_n = 0;
    #1;
    total++; if (outst_cnt !== 2'd0 || err_unexp !== 1'b0) begin
      bad++; $display("FAIL rmid_clear got cnt=%0d err=%b want 0/0", outst_cnt, err_unexp); end
    total++; if (s_req !== 1'b1) begin bad++; $display("FAIL rmid_sreq got %b want 1", s_req); end
    sb.delete(); exp_last = 1;
    @(negedge clk);
    rst_n = 1;
    m0_req = 0;
    tick();
    s_resp = 2'b01; s_rdata = 32'hC0FFEE;
    @(negedge clk);
    total++; if ({m0_resp, m0_rdata, m1_resp, m1_rdata} !== 68'h0) begin
      bad++; $display("FAIL rmid_stray_drop got %h want 0", {m0_resp, m0_rdata, m1_resp, m1_rdata}); end
    tick();
    s_resp = 2'b00;
    total++; if (err_unexp !== 1'b1) begin bad++; $display("FAIL rmid_stray_err got %b want 1", err_unexp); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_pipelined_order();
    test_full_stall();
    test_error_unexpected();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
